wait_responder: RTL and testbench

WAIT_RESPONDER -- requirements
Module: wait_responder

---
 rtl/wait_pkg.sv | 20 ++
 rtl/wait_down_counter.sv | 39 +++
 rtl/wait_responder.sv | 102 ++++++++++
 tb/tb_wait_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wait_pkg.sv
// Shared definitions for the wait responder.
//   state_e      : FSM state encoding (IDLE=0, WAIT=1, RESPOND=2)
//   *_W_DEF      : default widths for data, per-request wait count and
//                  completed-transaction counter
//   RSP_INC      : value added to the captured request data to form the response
package wait_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int DLY_W_DEF  = 4;
  localparam int CNT_W_DEF  = 16;

  localparam int RSP_INC = 1;

endpackage

// File: rtl/wait_down_counter.sv
// Loadable down-counter with zero detect.
//   clk, reset : clock and synchronous active-high reset (count -> 0)
//   load       : load load_val (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one; saturates at zero
//   zero       : count is zero (registered value, no input path)
module wait_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/wait_responder.sv
// Request/response responder with a programmable per-request wait.
// A request is captured in IDLE, held for req_delay cycles in WAIT, then
// answered with req_data+1 in RESPOND until the requester takes it.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_data, req_delay : request payload and wait count
//   rsp_valid/rsp_ready : response handshake (valid only in RESPOND)
//   rsp_data            : captured data + 1, two's-complement wrap
//   txn_count           : completed responses, wrapping
//   busy                : high in WAIT and RESPOND
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | ready for a request
// WAIT    | counting down the requested delay
// RESPOND | presenting the response until rsp_ready is sampled
module wait_responder
  import wait_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DLY_W  = DLY_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic signed [DATA_W-1:0] req_data,
  input  logic        [DLY_W-1:0]  req_delay,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic signed [DATA_W-1:0] rsp_data,
  input  logic                     rsp_ready,
  output logic        [CNT_W-1:0]  txn_count,
  output logic                     busy
);

  state_e                     state_q, state_d;
  logic signed [DATA_W-1:0]   data_q, data_d;
  logic        [CNT_W-1:0]    txn_q, txn_d;
  logic                       cnt_load, cnt_dec, cnt_zero;

  wait_down_counter #(.W(DLY_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (req_delay),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    txn_d    = txn_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          data_d   = req_data;
          cnt_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // Zero is seen one edge after the count reaches it, giving D+1 edges
        // from accept to the first rsp_valid.
        if (cnt_zero) begin
          state_d = RESPOND;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          state_d = IDLE;
          txn_d   = txn_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      txn_q   <= txn_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESPOND);
  assign busy      = (state_q == WAIT) || (state_q == RESPOND);
  assign rsp_data  = data_q + DATA_W'(RSP_INC);
  assign txn_count = txn_q;

endmodule

// File: tb/tb_wait_responder.sv
module tb_wait_responder;

  localparam int DATA_W = 32;
  localparam int DLY_W  = 4;
  localparam int CNT_W  = 2;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                dly;
  } exp_t;

  logic                     clk;
  logic                     reset;
  logic                     req_valid;
  logic signed [DATA_W-1:0] req_data;
  logic        [DLY_W-1:0]  req_delay;
  logic                     req_ready;
  logic                     rsp_valid;
  logic signed [DATA_W-1:0] rsp_data;
  logic                     rsp_ready;
  logic        [CNT_W-1:0]  txn_count;
  logic                     busy;

  wait_responder #(.DATA_W(DATA_W), .DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_delay (req_delay),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .txn_count (txn_count),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   txn_model = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on completion.
  int                acc_edge = -1;
  bit                in_txn = 0;
  bit                prev_rv = 0;
  bit                chk_cnt_next = 0;
  logic [DATA_W-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      acc_edge     = -1;
      in_txn       = 0;
      prev_rv      = 0;
      chk_cnt_next = 0;
    end else begin
      if (chk_cnt_next) begin
        chk("txn_count", DATA_W'(txn_count), DATA_W'(txn_model));
        chk("idle_req_ready", DATA_W'(req_ready), 1);
        chk("idle_busy", DATA_W'(busy), 0);
        chk_cnt_next = 0;
      end
      if (rsp_valid) begin
        if (!prev_rv) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            chk("rsp_data", rsp_data, exp_q[0].data);
            chk("latency", DATA_W'(edge_cnt - acc_edge), DATA_W'(exp_q[0].dly + 1));
          end
          hold_data = rsp_data;
        end else begin
          chk("rsp_stable", rsp_data, hold_data);
        end
        chk("rsp_req_ready", DATA_W'(req_ready), 0);
        chk("rsp_busy", DATA_W'(busy), 1);
        if (rsp_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          txn_model    = (txn_model + 1) % (1 << CNT_W);
          chk_cnt_next = 1;
          in_txn       = 0;
        end
      end else if (in_txn && edge_cnt >= acc_edge) begin
        chk("wait_busy", DATA_W'(busy), 1);
        chk("wait_req_ready", DATA_W'(req_ready), 0);
      end
      if (req_valid && req_ready) begin
        acc_edge = edge_cnt + 1;
        in_txn   = 1;
      end
      prev_rv = rsp_valid && !rsp_ready;
    end
  end

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (req_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("req_ready_timeout", 0, 1);
  endtask

  task automatic run_txn(input logic [DATA_W-1:0] d, input int dly, input int bp,
                         input bit junk);
    bit ok = 0;
    wait_ready();
    req_valid = 1'b1;
    req_data  = d;
    req_delay = DLY_W'(dly);
    exp_q.push_back('{data: d + DATA_W'(1), dly: dly});
    @(posedge clk); #1;
    if (junk) begin
      req_valid = 1'b1;
      req_data  = 32'sd9;
      req_delay = DLY_W'($urandom);
    end else begin
      req_valid = 1'b0;
      req_data  = $urandom;
    end
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    repeat (bp) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    txn_model = 0;
    chk("rst_req_ready", DATA_W'(req_ready), 1);
    chk("rst_rsp_valid", DATA_W'(rsp_valid), 0);
    chk("rst_txn_count", DATA_W'(txn_count), 0);
    chk("rst_busy", DATA_W'(busy), 0);
    chk("rst_rsp_data", rsp_data, 1);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_data  = '0;
    req_delay = '0;
    rsp_ready = 1'b0;

    do_reset(2);

    run_txn(32'd1, 4, 0, 0);
    run_txn(32'hFFFF_FFFF, 0, 3, 0);
    run_txn(32'h7FFF_FFFF, 2, 1, 0);
    run_txn(32'h0000_1234, 3, 0, 1);
    run_txn(32'h8000_0000, 15, 2, 1);

    for (int i = 0; i < 20; i++) begin
      run_txn($urandom, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    // Abandon a transaction in WAIT with the counter at 2.
    wait_ready();
    req_valid = 1'b1;
    req_data  = 32'sd5;
    req_delay = 4'd5;
    exp_q.push_back('{data: 32'd6, dly: 5});
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    do_reset(1);
    repeat (25) @(posedge clk);
    #1;
    chk("post_abort_txn", DATA_W'(txn_count), 0);

    run_txn(32'd100, 1, 0, 0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
